// File: rtl/axi_id_remap_cnt_table_if.sv
// ---------------------------------------------------------------------------
// axi_id_remap_cnt_table_if
//
// Bundles the lookup, push and pop signals of the ID remap counting table.
// Member names keep their table-side direction suffix (_i = into the table,
// _o = out of the table) so both sides read the same names.
//
//   slave  modport : the table itself
//   master modport : the upstream ID-remapping handshake logic
//
// Parameters:
//   InpIdWidth : width of the upstream (input) AXI ID
//   IdxWidth   : width of the output ID / table index
// ---------------------------------------------------------------------------
interface axi_id_remap_cnt_table_if #(
  parameter int unsigned InpIdWidth = 4,
  parameter int unsigned IdxWidth   = 2
);

  // Free-entry search
  logic                  free_o;
  logic [IdxWidth-1:0]   free_oup_id_o;
  logic                  full_o;

  // Input-ID lookup
  logic [InpIdWidth-1:0] exists_inp_id_i;
  logic                  exists_o;
  logic [IdxWidth-1:0]   exists_oup_id_o;
  logic                  exists_full_o;

  // Push (new transaction)
  logic                  push_i;
  logic [InpIdWidth-1:0] push_inp_id_i;
  logic [IdxWidth-1:0]   push_oup_id_i;

  // Pop (retired transaction)
  logic                  pop_i;
  logic [IdxWidth-1:0]   pop_oup_id_i;
  logic [InpIdWidth-1:0] pop_inp_id_o;

  modport slave (
    output free_o, free_oup_id_o, full_o,
    input  exists_inp_id_i,
    output exists_o, exists_oup_id_o, exists_full_o,
    input  push_i, push_inp_id_i, push_oup_id_i,
    input  pop_i, pop_oup_id_i,
    output pop_inp_id_o
  );

  modport master (
    input  free_o, free_oup_id_o, full_o,
    output exists_inp_id_i,
    input  exists_o, exists_oup_id_o, exists_full_o,
    output push_i, push_inp_id_i, push_oup_id_i,
    output pop_i, pop_oup_id_i,
    input  pop_inp_id_o
  );

endinterface

// File: rtl/axi_id_remap_cnt_table.sv
// ---------------------------------------------------------------------------
// axi_id_remap_cnt_table
//
// ID remap table with per-entry transaction counters. Each entry binds one
// input ID to one output ID (the entry index); outstanding transactions with
// the same input ID share an entry and are counted, which keeps same-ID
// ordering and saves table slots. One instance per direction (AW/B, AR/R).
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears every entry
//   tbl     : slave side of axi_id_remap_cnt_table_if
//             free_o / free_oup_id_o / full_o        lowest free entry
//             exists_inp_id_i -> exists_o / exists_oup_id_o / exists_full_o
//             push_i / push_inp_id_i / push_oup_id_i  add a transaction
//             pop_i / pop_oup_id_i -> pop_inp_id_o    retire a transaction
//
// All outputs are combinational from the table state and the lookup inputs;
// push and pop take effect on the next rising clock edge.
// ---------------------------------------------------------------------------
module axi_id_remap_cnt_table #(
  parameter int unsigned InpIdWidth    = 4,
  parameter int unsigned MaxUniqInpIds = 4,
  parameter int unsigned MaxTxnsPerId  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  axi_id_remap_cnt_table_if.slave   tbl
);

  localparam int unsigned IdxWidth = (MaxUniqInpIds > 1) ? $clog2(MaxUniqInpIds) : 1;
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

  typedef logic [InpIdWidth-1:0] id_t;
  typedef logic [IdxWidth-1:0]   idx_t;
  typedef logic [CntWidth-1:0]   cnt_t;

  localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

  id_t  inp_id_q [MaxUniqInpIds];
  id_t  inp_id_d [MaxUniqInpIds];
  cnt_t cnt_q    [MaxUniqInpIds];
  cnt_t cnt_d    [MaxUniqInpIds];

  logic [MaxUniqInpIds-1:0] push_sel, pop_sel;
  logic free, exists, exists_full;
  idx_t free_idx, exists_idx;
  id_t  pop_id, push_stored_id;
  cnt_t pop_cnt, push_cnt;

  // With a single entry the index carries no information, so every index
  // value addresses entry 0.
  function automatic logic idx_hit(input idx_t idx, input int i);
    if (MaxUniqInpIds == 1) return 1'b1;
    return idx == idx_t'(i);
  endfunction

  // Lookups: lowest-index free entry, lowest-index live match, and the
  // entries addressed by push/pop.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    free           = 1'b0;
    free_idx       = '0;
    exists         = 1'b0;
    exists_idx     = '0;
    exists_full    = 1'b0;
    pop_id         = '0;
    pop_cnt        = '0;
    push_stored_id = '0;
    push_cnt       = '0;
    push_sel       = '0;
    pop_sel        = '0;
    for (int i = 0; i < int'(MaxUniqInpIds); i++) begin
      if (!free && cnt_q[i] == '0) begin
        free     = 1'b1;
        free_idx = idx_t'(i);
      end
      if (!exists && cnt_q[i] != '0 && inp_id_q[i] == tbl.exists_inp_id_i) begin
        exists      = 1'b1;
        exists_idx  = idx_t'(i);
        exists_full = (cnt_q[i] == CntMax);
      end
      if (idx_hit(tbl.pop_oup_id_i, i)) begin
        pop_id  = inp_id_q[i];
        pop_cnt = cnt_q[i];
      end
      if (idx_hit(tbl.push_oup_id_i, i)) begin
        push_stored_id = inp_id_q[i];
        push_cnt       = cnt_q[i];
      end
      push_sel[i] = tbl.push_i && idx_hit(tbl.push_oup_id_i, i);
      pop_sel[i]  = tbl.pop_i  && idx_hit(tbl.pop_oup_id_i, i);
    end
  end

  // Next state. A push and a pop on the same entry cancel out; a push into
  // a free entry (re)binds its input ID.
  always_comb begin
    for (int i = 0; i < int'(MaxUniqInpIds); i++) begin
      // NOTE: combinational logic uses blocking '=' so later statements see
      // the updated value; registers below use non-blocking '<='.
      inp_id_d[i] = inp_id_q[i];
      cnt_d[i]    = cnt_q[i];
      if (push_sel[i] && !pop_sel[i]) begin
        if (cnt_q[i] == '0) begin
          inp_id_d[i] = tbl.push_inp_id_i;
          cnt_d[i]    = cnt_t'(1);
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end else if (pop_sel[i] && !push_sel[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the table is a register array, not a RAM macro, so every entry
      // is cleared by reset; a reset must discard all outstanding IDs.
      for (int i = 0; i < int'(MaxUniqInpIds); i++) begin
        inp_id_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MaxUniqInpIds); i++) begin
        inp_id_q[i] <= inp_id_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign tbl.free_o          = free;
  assign tbl.free_oup_id_o   = free_idx;
  assign tbl.full_o          = ~free;
  assign tbl.exists_o        = exists;
  assign tbl.exists_oup_id_o = exists_idx;
  assign tbl.exists_full_o   = exists_full;
  assign tbl.pop_inp_id_o    = pop_id;

`ifndef SYNTHESIS
  initial begin
    if (InpIdWidth < 1)    $fatal(1, "InpIdWidth must be at least 1");
    if (MaxUniqInpIds < 1) $fatal(1, "MaxUniqInpIds must be at least 1");
    if (MaxTxnsPerId < 1)  $fatal(1, "MaxTxnsPerId must be at least 1");
    // The caller zero-extends this index into its output ID.
    if ($bits(tbl.free_oup_id_o) != IdxWidth)
      $fatal(1, "interface IdxWidth must equal %0d", IdxWidth);
  end

  // Opening a free entry must use the entry the free search offers.
  a_push_free : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (tbl.push_i && push_cnt == '0) |-> (free && tbl.push_oup_id_i == free_idx))
    else $error("push into free entry other than free_oup_id_o");

  // Joining a live entry needs the same input ID and room in the counter.
  a_push_live : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (tbl.push_i && push_cnt != '0) |->
      (push_stored_id == tbl.push_inp_id_i && push_cnt < CntMax))
    else $error("push into live entry with wrong ID or full counter");

  a_pop_live : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tbl.pop_i |-> (pop_cnt != '0))
    else $error("pop from free entry");

  a_push_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tbl.push_i |-> (MaxUniqInpIds == 1 || int'(tbl.push_oup_id_i) < int'(MaxUniqInpIds)))
    else $error("push_oup_id_i out of range");

  a_pop_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    tbl.pop_i |-> (MaxUniqInpIds == 1 || int'(tbl.pop_oup_id_i) < int'(MaxUniqInpIds)))
    else $error("pop_oup_id_i out of range");
`endif

endmodule

// File: doc/axi_id_remap_cnt_table.md
Name: axi_id_remap_cnt_table

Overview:
- Next-generation ID remap table for AXI ID remappers; one instance per direction (AW/B, AR/R).
- Each entry maps one unique input ID to one output ID (the entry index).
- Each entry carries a transaction counter, so several outstanding transactions with the same input ID share one output ID. This keeps same-ID ordering and uses table slots efficiently.
- Sits between the upstream ID-remapping handshake logic and the downstream port. Lookup outputs are combinational; state is registered.

Parameters:
- InpIdWidth, 4, width of input (upstream) AXI ID.
- MaxUniqInpIds, 4, number of table entries, i.e. number of distinct input IDs in flight; >= 1.
- MaxTxnsPerId, 4, maximum outstanding transactions per entry; >= 1.
- IdxWidth, derived = max($clog2(MaxUniqInpIds),1), output ID / index width.
- CntWidth, derived = $clog2(MaxTxnsPerId+1), counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- free_o  out  1  at least one entry has count 0
- free_oup_id_o  out  IdxWidth  lowest-index free entry (0 when none free)
- full_o  out  1  = ~free_o
- exists_inp_id_i  in  InpIdWidth  input ID to look up
- exists_o  out  1  an entry with count != 0 holds exists_inp_id_i
- exists_oup_id_o  out  IdxWidth  index of the matching entry (0 when no match)
- exists_full_o  out  1  matching entry count == MaxTxnsPerId
- push_i  in  1  accept one transaction into an entry this cycle
- push_inp_id_i  in  InpIdWidth  input ID of the pushed transaction
- push_oup_id_i  in  IdxWidth  entry to push into
- pop_i  in  1  retire one transaction this cycle
- pop_oup_id_i  in  IdxWidth  entry to retire from (the response's output ID)
- pop_inp_id_o  out  InpIdWidth  stored input ID of entry pop_oup_id_i; combinational, valid whenever that entry's count != 0

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_ni, asynchronous, active-low.
- State per entry: inp_id[InpIdWidth], cnt[CntWidth]. An entry is free iff cnt == 0.
- Reset: all inp_id = 0 and all cnt = 0. Resulting outputs:
  - free_o = 1, full_o = 0, free_oup_id_o = 0
  - exists_o = 0, exists_oup_id_o = 0, exists_full_o = 0
  - pop_inp_id_o = 0
- Reset mid-operation discards all entries immediately (asynchronous).
- All outputs are combinational from state and inputs. There are no output registers; zero-cycle lookup latency.
- Free search: priority to the lowest index.
- Exists search: lowest-index entry with cnt != 0 and inp_id == exists_inp_id_i. The protocol guarantees at most one match.
- Push, effective next edge:
  - if cnt[push_oup_id_i] == 0: inp_id <= push_inp_id_i, cnt <= 1
  - else: cnt <= cnt + 1, inp_id unchanged
- Pop, effective next edge: cnt[pop_oup_id_i] <= cnt - 1. When it reaches 0 the entry is free from the next cycle; inp_id is retained but ignored.
- Push and pop in the same cycle:
  - Different entries: both apply.
  - Same entry with cnt >= 1: cnt unchanged, inp_id unchanged.
  - Push into a free entry plus pop of a different entry whose cnt is 1: both apply. The freed entry is not visible to free_o until the next cycle; there is no same-cycle bypass.
- Caller protocol, checked by assertions under ifndef SYNTHESIS. Each rule is an error if violated:
  - push into a free entry requires free_o and push_oup_id_i == free_oup_id_o
  - push into a non-free entry requires stored inp_id == push_inp_id_i and cnt < MaxTxnsPerId
  - pop requires cnt[pop_oup_id_i] != 0
  - pop_oup_id_i < MaxUniqInpIds and push_oup_id_i < MaxUniqInpIds
- Intended caller flow:
  - exists_o & ~exists_full_o: push to exists_oup_id_o
  - exists_o & exists_full_o: stall
  - ~exists_o & free_o: push to free_oup_id_o
  - otherwise: stall
- Counter arithmetic is unsigned, width CntWidth, and never wraps under a legal protocol.
- MaxUniqInpIds == 1: IdxWidth = 1, and the index MSB is ignored beyond entry 0.
- Parameter checks in an initial block:
  - InpIdWidth >= 1, MaxUniqInpIds >= 1, MaxTxnsPerId >= 1
  - IdxWidth is the output ID width the caller zero-extends

Test Plan:
- Reset, then idle -> free_o=1, full_o=0, free_oup_id_o=0, exists_o=0 for exists_inp_id_i=0.
- Defaults. Push ID 0x5 to entry 0, then lookup 0x5 -> exists_o=1, exists_oup_id_o=0, exists_full_o=0, free_oup_id_o=1. Push 0x5 three more times -> exists_full_o=1 with cnt=4.
- Push IDs 0x1, 0x2, 0x3, 0x4 into entries 0-3 -> full_o=1. Pop entry 2 -> next cycle free_o=1, free_oup_id_o=2, and a lookup of 0x3 gives exists_o=0.
- Entry 1 holds 0xA with cnt=2. Same-cycle push(0xA → 1) and pop(1) -> cnt stays 2 and pop_inp_id_o=0xA. Two further pops -> entry 1 free.
- Entry 0 holds cnt=1. Pop entry 0 while pushing a new ID 0x7 to free_oup_id_o=1 -> entry 0 free, entry 1 = {0x7,1}. A push to entry 0 in that same cycle is illegal and raises an assertion.
- Fill the table, deassert rst_ni asynchronously mid-cycle -> free_o=1 and exists_o=0 immediately, before the next clock edge.
